bc_tx_msg_reader: RTL and testbench
===================================

Name: bc_tx_msg_reader

Overview:
- Bus Controller transmit-side sequencer. It reads one MIL-STD-1553 message (command word plus optional data words) out of the BC transmit buffer RAM, a 1024x40 dual-port SRAM with 1-cycle read latency.
- It hands words one at a time to the Manchester encoder over a valid/ready handshake.
- It is the read-out counterpart of the BC receive-buffer write path. It sits between the host/scheduler (START) and the encoder.

Parameters:
- ADDR_W, 10, RAM address width; buffer depth 2**ADDR_W.
- RAM_W, 40, RAM word width; only bits [16:0] are used.
- RD_LAT, 1, RAM read latency in cycles; only 1 is supported.

Ports:
- CLK  in  1  single system clock, rising edge.
- RESETN  in  1  reset, synchronous, active-low.
- START  in  1  1-cycle request to send the message at START_ADDR; honoured only in IDLE.
- START_ADDR  in  ADDR_W  RAM address of the command word.
- ABORT  in  1  terminate the current message; honoured in any non-IDLE state.
- RAM_ADDR  out  ADDR_W  read address to RAM port B (registered).
- RAM_REN  out  1  read enable to RAM port B (registered).
- RAM_DOUT  in  RAM_W  RAM read data; valid the cycle after the address edge.
- TX_DATA  out  16  word to the encoder.
- TX_SYNC  out  1  1 = command/status sync, 0 = data sync.
- TX_VALID  out  1  TX_DATA/TX_SYNC valid.
- TX_READY  in  1  encoder accepts the word when TX_VALID&TX_READY.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  1-cycle pulse when the last word is accepted or after an abort.
- ERR  out  1  sticky error flag; cleared on the next accepted START.

Behaviour:
- Reset (RESETN=0 at an edge): state IDLE. RAM_ADDR=0, RAM_REN=0, TX_DATA=0, TX_SYNC=0, TX_VALID=0, BUSY=0, DONE=0, ERR=0.
- RAM word format: [15:0] 1553 word, [16] stored odd parity of [15:0] (used only with the optional feature), [39:17] ignored.
- State RD: RAM_REN=1, RAM_ADDR=ptr, held for one cycle. Next state WT.
- State WT: RAM_REN=0; RAM_DOUT is valid this cycle. At the edge: TX_DATA<=RAM_DOUT[15:0], TX_VALID<=1, TX_SYNC<=(word is command). Next state SEND.
- State SEND: TX_VALID, TX_DATA and TX_SYNC are held stable until TX_READY. At the handshake edge: TX_VALID<=0.
  - If words remain: ptr<=ptr+1 (wraps 1023->0), next state RD.
  - Otherwise: DONE<=1, next state IDLE.
- IDLE + START: ptr<=START_ADDR, RAM_ADDR<=START_ADDR, RAM_REN<=1, ERR<=0, state RD. First TX_VALID rises at the 2nd edge after the START edge.
- Word count is taken from the command word at the WT->SEND edge:
  - T/R=bit[10]. If T/R=1 (RT transmits), only the command word is sent.
  - If T/R=0, N=cmd[4:0], with 0 meaning 32. The message is 1+N words; data words carry TX_SYNC=0.
  - Mode codes (subaddress bits[9:5]=0 or 31) with T/R=0: N=1 if cmd[4]=1, else N=0.
- Remaining-word counter is 6 bits; it loads N and decrements per data-word handshake.
- Steady-state throughput: one word per 3 cycles plus encoder stall. No prefetch.
- ABORT outside IDLE: at the next edge TX_VALID<=0, RAM_REN<=0, DONE<=1, ERR<=1, state IDLE. ABORT has priority over a coincident TX_READY handshake.
- START while BUSY is ignored, with no side effects. START and ABORT together in IDLE: START wins; ABORT is ignored.
- Reset mid-message: all outputs return to reset values at that edge; no DONE pulse.
- A message spanning address 1023 continues at address 0.

Optional Feature:
- Macro: BC_TX_PARITY_CHECK_EN.
- With the macro defined: in WT, compute the odd parity of RAM_DOUT[15:0]. If it differs from RAM_DOUT[16]:
  - TX_VALID stays 0.
  - ERR<=1 and DONE<=1.
  - State goes to IDLE.
  - No further words are sent for this message.
- Without the macro: bit[16] is ignored and no parity logic is synthesised.

Test Plan:
- Receive command, T/R=0, count=3: RAM[0x010]=0x0823, RAM[0x011..0x013]=0xAAAA,0x5555,0x1234; START_ADDR=0x010, TX_READY tied 1.
  - Required: 4 handshakes, SYNC=1,0,0,0; DONE 1 cycle after the 4th; BUSY low afterwards.
- Transmit command: RAM[0x020]=0x0C25 (T/R=1); START.
  - Required: exactly 1 word 0x0C25 with SYNC=1, then DONE; no further RAM reads.
- Count=0 with wrap: START_ADDR=0x3F0, cmd=0x0820 (32 words).
  - Required: 33 words from addresses 0x3F0..0x3FF then 0x000..0x010; RAM_ADDR wraps cleanly.
- Encoder stall: TX_READY low for 50 cycles on the 2nd word.
  - Required: TX_DATA/TX_SYNC/TX_VALID stable for all 50 cycles; no extra RAM_REN.
- ABORT on the 3rd word coincident with TX_READY.
  - Required: DONE=1 and ERR=1 next cycle; IDLE; the next START clears ERR.
  - Also: START while BUSY is ignored; RESETN low mid-SEND gives reset values with no DONE.
- With BC_TX_PARITY_CHECK_EN: RAM[0x040]=0x0822 with bit16 wrong.
  - Required: no TX_VALID; ERR=1; DONE pulse.
  - Without the macro, the same stimulus transmits normally.

Source files
------------

// File: rtl/bc_tx_msg_reader.sv
`default_nettype none
// ============================================================================
//  Module   : bc_tx_msg_reader
//  Purpose  : MIL-STD-1553 Bus Controller transmit-side sequencer. Reads a
//             command word plus its data words from the BC transmit buffer
//             RAM (1-cycle read latency) and hands them one at a time to the
//             Manchester encoder over a valid/ready handshake.
//  Options  : BC_TX_PARITY_CHECK_EN - when defined, each word read from RAM is
//             checked against its stored odd-parity bit [16]; a mismatch
//             terminates the message with ERR and DONE.
//  Revision : 1.0 - initial release
// ============================================================================
module bc_tx_msg_reader #(
    parameter int ADDR_W = 10,
    parameter int RAM_W  = 40,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_ren_o,
    input  logic [RAM_W-1:0]  ram_dout_i,
    output logic [15:0]       tx_data_o,
    output logic              tx_sync_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WT   = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Only a single-cycle RAM read latency is implemented.
    generate
        if (RD_LAT != 1) begin : g_rd_lat_unsupported
            $error("bc_tx_msg_reader: only RD_LAT=1 is supported");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] ptr_q,      ptr_d;
    logic              ren_q,      ren_d;
    logic [15:0]       tx_data_q,  tx_data_d;
    logic              tx_sync_q,  tx_sync_d;
    logic              tx_valid_q, tx_valid_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [5:0]        cnt_q,      cnt_d;     // data words still to send
    logic              first_q,    first_d;   // next word is the command word

    // Word count decoded from the command word currently on RAM_DOUT.
    logic [15:0] w_word;
    logic [4:0]  w_sa;
    logic [5:0]  w_cmd_n;
    logic        w_par_err;

    assign w_word = ram_dout_i[15:0];
    assign w_sa   = w_word[9:5];

`ifdef BC_TX_PARITY_CHECK_EN
    // Bit 16 holds odd parity over [15:0]; upper bits carry no meaning here.
    logic w_unused_bits;
    assign w_unused_bits = ^ram_dout_i[RAM_W-1:17];
    assign w_par_err     = (~^w_word) != ram_dout_i[16];
`else
    // Parity bit and upper bits are ignored in this build.
    logic w_unused_bits;
    assign w_unused_bits = ^ram_dout_i[RAM_W-1:16];
    assign w_par_err     = 1'b0;
`endif

    // Decode the number of data words that follow the command word.
    always_comb begin
        w_cmd_n = 6'd0;
        if (w_word[10]) begin
            // RT transmits: the BC sends only the command word.
            w_cmd_n = 6'd0;
        end else if ((w_sa == 5'd0) || (w_sa == 5'd31)) begin
            // Mode code: bit 4 set means one associated data word.
            w_cmd_n = w_word[4] ? 6'd1 : 6'd0;
        end else if (w_word[4:0] == 5'd0) begin
            w_cmd_n = 6'd32;
        end else begin
            w_cmd_n = {1'b0, w_word[4:0]};
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            ren_q      <= 1'b0;
            tx_data_q  <= 16'h0000;
            tx_sync_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 6'd0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ren_q      <= ren_d;
            tx_data_q  <= tx_data_d;
            tx_sync_q  <= tx_sync_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
        end
    end

    // Next-state and next-register logic; ABORT overrides everything outside IDLE.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ren_d      = ren_q;
        tx_data_d  = tx_data_q;
        tx_sync_d  = tx_sync_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;
        first_d    = first_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ptr_d   = start_addr_i;
                    ren_d   = 1'b1;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = S_RD;
                end
            end

            S_RD: begin
                // Address was presented for exactly one cycle.
                ren_d   = 1'b0;
                state_d = S_WT;
            end

            S_WT: begin
                if (w_par_err) begin
                    // Corrupt word: never expose it to the encoder.
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tx_data_d  = w_word;
                    tx_sync_d  = first_q;
                    tx_valid_d = 1'b1;
                    if (first_q) begin
                        cnt_d = w_cmd_n;
                    end
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    first_d    = 1'b0;
                    if (cnt_q != 6'd0) begin
                        cnt_d   = cnt_q - 6'd1;
                        ptr_d   = ptr_q + C_ADDR_ONE;   // wraps naturally at the top
                        ren_d   = 1'b1;
                        state_d = S_RD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i && (state_q != S_IDLE)) begin
            tx_valid_d = 1'b0;
            ren_d      = 1'b0;
            done_d     = 1'b1;
            err_d      = 1'b1;
            state_d    = S_IDLE;
        end
    end

    // Output mapping: all outputs come straight from registers.
    always_comb begin
        ram_addr_o = ptr_q;
        ram_ren_o  = ren_q;
        tx_data_o  = tx_data_q;
        tx_sync_o  = tx_sync_q;
        tx_valid_o = tx_valid_q;
        busy_o     = (state_q != S_IDLE);
        done_o     = done_q;
        err_o      = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_bc_tx_msg_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bc_tx_msg_reader
//  Purpose  : Self-checking bench for bc_tx_msg_reader with a behavioural
//             1-cycle-latency transmit buffer RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bc_tx_msg_reader;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [9:0]  start_addr;
    logic        abort;
    logic [9:0]  ram_addr;
    logic        ram_ren;
    logic [39:0] ram_dout;
    logic [15:0] tx_data;
    logic        tx_sync;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        err;

    int tests_run;
    int tests_failed;

    logic [39:0] mem [1024];

    bc_tx_msg_reader #(
        .ADDR_W (10),
        .RAM_W  (40),
        .RD_LAT (1)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .start_i      (start),
        .start_addr_i (start_addr),
        .abort_i      (abort),
        .ram_addr_o   (ram_addr),
        .ram_ren_o    (ram_ren),
        .ram_dout_i   (ram_dout),
        .tx_data_o    (tx_data),
        .tx_sync_o    (tx_sync),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port B: registered read, data valid the cycle after the address edge.
    always @(posedge clk) begin
        if (ram_ren) ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] cmd;
        int          nw;      // expected total words (command + data)
        int          st_idx;  // word index to stall on, -1 for none
        int          st_len;  // stall length in cycles
        bit          inj;     // pulse START during the stall
    } vec_t;

    vec_t vt [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_word(input logic [9:0] a, input logic [15:0] d, input bit bad_par);
        mem[a] = {23'h5A5A5A, (~^d) ^ bad_par, d};
    endtask

    // Run one message and check every word, the DONE pulse, BUSY and RAM reads.
    task automatic run_msg(input logic [9:0] a, input int nw, input int st_idx,
                           input int st_len, input bit inj);
        int          got;
        int          stalled;
        int          rens;
        logic [9:0]  idx;
        logic [15:0] ed;
        logic        es;
        got = 0; stalled = 0; rens = 0;
        tx_ready   = 1'b1;
        start_addr = a;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; (cyc < nw * 3 + st_len + 20) && (got < nw); cyc++) begin
            start = 1'b0;
            if (ram_ren) rens++;
            if (tx_valid) begin
                idx = a + got[9:0];
                ed  = mem[idx][15:0];
                es  = (got == 0);
                if (got == st_idx && stalled < st_len) begin
                    check("stall_hold", {13'd0, ram_ren, tx_valid, tx_sync, tx_data},
                          {13'd0, 1'b0, 1'b1, es, ed});
                    if (inj && stalled == 1) begin
                        start      = 1'b1;
                        start_addr = 10'h3FF;
                    end
                    tx_ready = 1'b0;
                    stalled++;
                end else begin
                    check("word", {15'd0, tx_sync, tx_data}, {15'd0, es, ed});
                    tx_ready = 1'b1;
                    got++;
                end
            end else begin
                tx_ready = 1'b1;
            end
            tick();
        end
        check("word_count", got, nw);
        check("done_pulse", {29'd0, done, busy, tx_valid}, {29'd0, 3'b100});
        for (int k = 0; k < 3; k++) begin
            if (ram_ren) rens++;
            tick();
        end
        check("ram_reads", rens, nw);
        check("idle_after", {29'd0, done, busy, err}, 32'd0);
    endtask

    initial begin
        int got;
        int vseen;
        int dcnt;
        bit hit;

        tests_run = 0; tests_failed = 0;
        resetn = 1'b0; start = 1'b0; start_addr = '0; abort = 1'b0; tx_ready = 1'b1;
        ram_dout = '0;

        for (int i = 0; i < 1024; i++) set_word(i[9:0], (i[15:0] * 16'h9E37) ^ 16'h5A5A, 1'b0);
        set_word(10'h010, 16'h0823, 1'b0);
        set_word(10'h011, 16'hAAAA, 1'b0);
        set_word(10'h012, 16'h5555, 1'b0);
        set_word(10'h013, 16'h1234, 1'b0);
        set_word(10'h040, 16'h0822, 1'b1);   // wrong parity bit

        vt[0] = '{10'h010, 16'h0823,  4, -1,  0, 1'b0};  // receive, 3 data words
        vt[1] = '{10'h020, 16'h0C25,  1, -1,  0, 1'b0};  // RT transmit
        vt[2] = '{10'h3F0, 16'h0820, 33, -1,  0, 1'b0};  // 32 data words, wraps
        vt[3] = '{10'h100, 16'h0823,  4,  1, 50, 1'b0};  // stall on 2nd word
        vt[4] = '{10'h200, 16'h0010,  2, -1,  0, 1'b0};  // mode code sa=0, bit4=1
        vt[5] = '{10'h210, 16'h03E2,  1,  0,  4, 1'b1};  // mode code sa=31, START while busy

        repeat (3) tick();
        check("reset_data", {ram_addr, ram_ren, tx_sync, tx_valid, tx_data},
              {10'd0, 1'b0, 1'b0, 1'b0, 16'd0});
        check("reset_status", {29'd0, busy, done, err}, 32'd0);
        resetn = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            if (vt[v].addr != 10'h010) set_word(vt[v].addr, vt[v].cmd, 1'b0);
            run_msg(vt[v].addr, vt[v].nw, vt[v].st_idx, vt[v].st_len, vt[v].inj);
        end

        // ABORT coincident with the handshake of the 3rd word.
        got = 0; hit = 1'b0;
        tx_ready = 1'b1; start_addr = 10'h010; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 30 && !hit; cyc++) begin
            if (tx_valid && got == 2) begin
                abort = 1'b1;
                hit   = 1'b1;
            end else if (tx_valid) begin
                got++;
            end
            tick();
        end
        abort = 1'b0;
        check("abort_reached", {31'd0, hit}, 32'd1);
        check("abort_effect", {27'd0, done, err, busy, tx_valid, ram_ren}, {27'd0, 5'b11000});
        tick();
        check("abort_after", {29'd0, done, err, busy}, {29'd0, 3'b010});
        // Next START must clear ERR (checked at the end of the message).
        run_msg(vt[1].addr, vt[1].nw, -1, 0, 1'b0);

        // Reset in the middle of SEND.
        tx_ready = 1'b0; start_addr = 10'h010; start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
            if (tx_valid) hit = 1'b1;
            else tick();
        end
        check("rst_reach_send", {31'd0, hit}, 32'd1);
        resetn = 1'b0;
        tick();
        check("rst_mid_data", {ram_addr, ram_ren, tx_sync, tx_valid, tx_data},
              {10'd0, 1'b0, 1'b0, 1'b0, 16'd0});
        check("rst_mid_status", {29'd0, busy, done, err}, 32'd0);
        resetn = 1'b1; tx_ready = 1'b1;
        tick();
        check("rst_mid_after", {29'd0, busy, done, err}, 32'd0);

        // Word with a wrong stored parity bit.
`ifdef BC_TX_PARITY_CHECK_EN
        vseen = 0; dcnt = 0;
        start_addr = 10'h040; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (tx_valid) vseen++;
            if (done) dcnt++;
            tick();
        end
        check("par_no_valid", vseen, 0);
        check("par_done", dcnt, 1);
        check("par_err", {30'd0, err, busy}, {30'd0, 2'b10});
`else
        vseen = 0; dcnt = 0;
        run_msg(10'h040, 3, -1, 0, 1'b0);
        check("par_ignored", vseen + dcnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
